// File: rtl/nvram_upload_if.sv
// HPS ioctl upload channel: the HPS side (master) issues read strobes, the core side (slave)
// answers with a byte and stalls the HPS with ioctl_wait while it is being fetched.
interface nvram_upload_if;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait
    );
endinterface

// File: rtl/nvram_upload.sv
// Game-owned NVRAM byte store served to the HPS over the ioctl upload path.
// Optional NVRAM_DIRTY_EN adds a "changed since last full upload" flag.
module nvram_upload #(
    parameter int          AW    = 8,
    parameter logic [15:0] INDEX = 16'd4,
    parameter logic [7:0]  FILL  = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    nvram_upload_if.slave ioctl,
    input  logic          game_we,
    input  logic [AW-1:0] game_addr,
    input  logic [7:0]    game_data,
    output logic [7:0]    game_q,
    output logic          busy,
    output logic          dirty
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic        wait_q, wait_d;
    logic [7:0]  din_q, din_d;
    logic [26:0] addr_q, addr_d;
    logic        busy_q;
    logic [7:0]  game_rd_q;
    logic [7:0]  ram_b_q;
    logic        sel;
    logic        out_of_range;

    // Power-up content only; reset deliberately leaves the stored bytes alone.
    logic [7:0] ram [0:DEPTH-1] = '{default: FILL};

    assign sel          = ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);
    assign out_of_range = (addr_q >> AW) != 27'd0;

    // Port A: game read/write
    always_ff @(posedge clk_sys) begin
        if (game_we) begin
            ram[game_addr] <= game_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            game_rd_q <= 8'd0;
        end else begin
            game_rd_q <= ram[game_addr];
        end
    end

    // Port B: upload read at the latched address, old data on a same-cycle game write
    always_ff @(posedge clk_sys) begin
        ram_b_q <= ram[addr_q[AW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        din_d   = din_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (busy_q && ioctl.ioctl_rd) begin
                    addr_d  = ioctl.ioctl_addr;
                    wait_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!sel) begin
                    wait_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sel) begin
                    din_d = out_of_range ? FILL : ram_b_q;
                end
                wait_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            din_q   <= 8'd0;
            addr_q  <= 27'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            busy_q  <= sel;
        end
    end

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = wait_q;
    assign busy             = busy_q;
    assign game_q           = game_rd_q;

`ifdef NVRAM_DIRTY_EN
    localparam logic [26:0] LAST_ADDR = 27'(DEPTH - 1);

    logic       pend_we_q;
    logic [7:0] pend_data_q;
    logic       last_full_q;
    logic       dirty_q, dirty_d;
    logic       session_end;

    assign session_end = busy_q && !sel;

    // game_rd_q holds the pre-write byte one cycle after the write, which is the compare source.
    always_comb begin
        dirty_d = dirty_q;
        if (session_end && last_full_q && !game_we) begin
            dirty_d = 1'b0;
        end
        if (pend_we_q && (game_rd_q != pend_data_q)) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_we_q   <= 1'b0;
            pend_data_q <= 8'd0;
            last_full_q <= 1'b0;
            dirty_q     <= 1'b0;
        end else begin
            pend_we_q   <= game_we;
            pend_data_q <= game_data;
            dirty_q     <= dirty_d;
            if (session_end) begin
                last_full_q <= 1'b0;
            end else if (state_q == S_DATA && sel) begin
                last_full_q <= (addr_q == LAST_ADDR);
            end
        end
    end

    assign dirty = dirty_q;
`else
    assign dirty = 1'b0;
`endif

endmodule

// File: doc/nvram_upload.md
# nvram_upload

Core-side responder for the HPS upload (core-to-HPS) direction of the ioctl channel. It owns a small byte RAM written by game logic (high-score table, operator settings) and serves it to the HPS on `ioctl_rd` requests, stalling the HPS with `ioctl_wait` while each byte is fetched. It sits beside `hps_io` in `emu`, complementing the download path that loads DIP switches.

## Interface
Parameters:
- `AW`, 8, RAM address width; depth is 2^AW bytes.
- `INDEX`, 16'd4, `ioctl_index` value that selects this block.
- `FILL`, 8'hFF, byte returned for out-of-range addresses; also the RAM power-up content.

Ports:
- `clk_sys`  in  1  system clock; all logic is on this clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_upload`  in  1  HPS upload session active.
- `ioctl_index`  in  16  upload target selector.
- `ioctl_rd`  in  1  one-cycle read strobe from HPS.
- `ioctl_addr`  in  27  byte address of the read.
- `ioctl_din`  out  8  read data to HPS.
- `ioctl_wait`  out  1  high while a read is being served.
- `game_we`  in  1  game write strobe.
- `game_addr`  in  AW  game address.
- `game_data`  in  8  game write data.
- `game_q`  out  8  game read data, registered.
- `busy`  out  1  upload session for `INDEX` in progress.
- `dirty`  out  1  RAM changed since last complete upload (only with `NVRAM_DIRTY_EN`).

## Operation
- RAM: true dual-port, 2^AW x 8. Port A is game (read/write), port B is upload (read-only). Contents initialised to `FILL` at configuration and **not** cleared by `reset`.
- Session: `sel = ioctl_upload && ioctl_index==INDEX`. `busy` is `sel` registered one cycle.
- FSM states: IDLE, FETCH, DATA.
  - IDLE: if `busy` and `ioctl_rd`, latch `ioctl_addr`, set `ioctl_wait`=1, go to FETCH.
  - FETCH: the RAM is read at the latched address. Go to DATA.
  - DATA: `ioctl_din` <= RAM output, or `FILL` if `ioctl_addr[26:AW]`!=0. Set `ioctl_wait`=0. Go to IDLE.
- `ioctl_rd` seen outside IDLE is ignored (protocol violation; no queueing).
- If `sel` drops in FETCH or DATA, go to IDLE, clear `ioctl_wait` and leave `ioctl_din` unchanged.
- Port A: if `game_we`, write `game_data` at `game_addr`. `game_q` <= RAM[`game_addr`] each cycle. Writes are accepted during a session; port-B collision at the same address returns the old byte (read-before-write).

## Timing
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `busy`=0, `game_q`=0, `dirty`=0, FSM=IDLE.
- Read latency: `ioctl_rd` sampled high at edge N. `ioctl_wait`=1 after N. `ioctl_din` is valid and `ioctl_wait`=0 after N+2. Minimum rd-to-rd spacing is 3 cycles.
- `busy` follows `sel` with 1-cycle delay. An `ioctl_rd` in the same cycle that `sel` first rises is ignored.
- `game_q` has 1-cycle latency. A write followed by a read of the same address in the next cycle returns the new byte.
- `reset` mid-read forces IDLE and `ioctl_wait`=0 immediately (asynchronous).

## Configuration
- `NVRAM_DIRTY_EN` defined:
  - `dirty` sets on any `game_we` whose data differs from the stored byte; the compare uses a read-modify-write, so one write is accepted per 2 cycles at the same address.
  - `dirty` clears when a session falls while the last served address was 2^AW-1 (full upload).
  - A write in the clearing cycle wins, and `dirty` stays 1.
- Not defined: `dirty` is tied to 0, with no compare logic; writes have no spacing limit.

## Test plan
- Reset, then session with `INDEX`=4: `ioctl_rd` addr 0 → `ioctl_wait` high 2 cycles, `ioctl_din`=8'hFF.
- `game_we` addr 8'h10 data 8'hA5, then upload read addr 16 → `ioctl_din`=8'hA5, latency exactly 2 cycles.
- Read addr 300 with AW=8 → `ioctl_din`=8'hFF. Read with `ioctl_index`=0 → no `ioctl_wait`, `ioctl_din` unchanged.
- Drop `ioctl_upload` during FETCH → `ioctl_wait`=0 next cycle, FSM IDLE, next session read works normally.
- `NVRAM_DIRTY_EN`: write 8'h01 → `dirty`=1. Rewrite 8'h01 after a full upload → `dirty` stays 0. Partial upload to addr 100 then end → `dirty` stays 1.
- Assert `reset` mid-read → all outputs return to reset values asynchronously. RAM byte 8'hA5 is still present after reset.
